// File: rtl/ex_forward_ctrl_if.sv
// Pipeline <-> hazard/forwarding controller bundle.
// master: the pipeline datapath (drives register numbers and stage flags).
// slave : ex_forward_ctrl (returns mux selects, stall and flush controls).
interface ex_forward_ctrl_if;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] writeregE;
    logic [4:0] writeregM;
    logic [4:0] writeregW;
    logic       regwriteE;
    logic       regwriteM;
    logic       regwriteW;
    logic       memtoregE;
    logic       memtoregM;
    logic       branchD;
    logic       divstartE;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       forwardAD;
    logic       forwardBD;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushE;
    logic       div_busy;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, divstartE,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, stallE, flushE, div_busy
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, divstartE,
        output forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, stallE, flushE, div_busy
    );
endinterface

// File: rtl/ex_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Drives EX operand mux selects, ID branch-compare forwarding and the
// F/D/E stall/flush controls; holds the pipeline during multi-cycle divides.
// Optional macro FWD_STATS_EN adds fwd_cnt / stall_cnt activity counters.
module ex_forward_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_forward_ctrl_if.slave   bus
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]        fwd_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [4:0]       src_e [2];
    logic [1:0][1:0]  fwd_e;
    logic             lwstall;
    logic             brstall;
    logic             divstall;

    // A producer matches a consumer only when it writes a real register ($0 never matches).
    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    assign src_e[0] = bus.rsE;
    assign src_e[1] = bus.rtE;

    // EX operand selects: MEM result wins over WB when both hold the register.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ex_fwd
            assign fwd_e[gi] = hit(bus.regwriteM, bus.writeregM, src_e[gi]) ? 2'b10 :
                               hit(bus.regwriteW, bus.writeregW, src_e[gi]) ? 2'b01 :
                                                                               2'b00;
        end
    endgenerate

    assign bus.forwardAE = fwd_e[0];
    assign bus.forwardBE = fwd_e[1];
    assign bus.forwardAD = hit(bus.regwriteM, bus.writeregM, bus.rsD);
    assign bus.forwardBD = hit(bus.regwriteM, bus.writeregM, bus.rtD);

    // Load in EX feeding an ID source: one bubble is unavoidable.
    assign lwstall = hit(bus.memtoregE, bus.rtE, bus.rsD) || hit(bus.memtoregE, bus.rtE, bus.rtD);

    // Branch compares in ID: wait for an ALU result still in EX or a load still in MEM.
    assign brstall = bus.branchD &&
                     (hit(bus.regwriteE, bus.writeregE, bus.rsD) ||
                      hit(bus.regwriteE, bus.writeregE, bus.rtD) ||
                      hit(bus.memtoregM, bus.writeregM, bus.rsD) ||
                      hit(bus.memtoregM, bus.writeregM, bus.rtD));

    // Divide FSM state and down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Divide FSM next state. The IDLE cycle that accepts the divide is the first
    // stall cycle, so BUSY lasts DIV_CYCLES-1 cycles: leave as the counter hits 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.divstartE) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign divstall     = ((state == IDLE) && bus.divstartE) || (state == BUSY);
    assign bus.div_busy = (state != IDLE);

    // While a divide holds EX, the instruction in EX must be kept, not bubbled.
    assign bus.stallF = lwstall | brstall | divstall;
    assign bus.stallD = lwstall | brstall | divstall;
    assign bus.stallE = divstall;
    assign bus.flushE = (lwstall | brstall) & ~divstall;

`ifdef FWD_STATS_EN
    // Activity counters: forwarding cycles and front-end stall cycles, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((|bus.forwardAE) || (|bus.forwardBE) || bus.forwardAD || bus.forwardBD) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
            if (bus.stallF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Self-checking bench for ex_forward_ctrl (DIV_CYCLES=4).
// Expected output vectors are queued as stimulus is applied and compared
// against the DUT outputs when they are sampled.
module tb_ex_forward_ctrl;

    logic clk;
    logic rst_n;

    ex_forward_ctrl_if bus ();

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt;
    logic [31:0] stall_cnt;
`endif

    ex_forward_ctrl #(
        .DIV_CYCLES (4),
        .CNT_W      (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt   (fwd_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [10:0] obs;
    assign obs = {bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.forwardBD,
                  bus.stallF, bus.stallD, bus.stallE, bus.flushE, bus.div_busy};

    // Expected vector; stallF and stallD are always equal, so one argument drives both.
    function automatic logic [10:0] ev(logic [1:0] fae, logic [1:0] fbe, logic fad, logic fbd,
                                       logic stl, logic ste, logic fl, logic busy);
        return {fae, fbe, fad, fbd, stl, stl, ste, fl, busy};
    endfunction

    // Reference EX select: start at WB, let a MEM match override it.
    function automatic logic [1:0] model_ex(logic [4:0] src, logic mwe, logic [4:0] mdst,
                                            logic wwe, logic [4:0] wdst);
        logic [1:0] r;
        r = 2'b00;
        if (src != 5'd0) begin
            if (wwe && wdst == src) r = 2'b01;
            if (mwe && mdst == src) r = 2'b10;
        end
        return r;
    endfunction

    task automatic check_val(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end else begin
            $display("txn %-14s outputs=%h", tag, observed);
        end
    endtask

    task automatic compare_out();
        exp_t x;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        check_val(x.tag, {21'd0, obs}, {21'd0, x.v});
    endtask

    // Apply the current inputs for one clock, compare on the falling edge.
    task automatic step(string tag, logic [10:0] v);
        sb.push_back('{tag, v});
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    // Compare without a clock edge (asynchronous effects).
    task automatic now(string tag, logic [10:0] v);
        sb.push_back('{tag, v});
        #1;
        compare_out();
    endtask

    task automatic clear_inputs();
        bus.rsD = 0; bus.rtD = 0; bus.rsE = 0; bus.rtE = 0;
        bus.writeregE = 0; bus.writeregM = 0; bus.writeregW = 0;
        bus.regwriteE = 0; bus.regwriteM = 0; bus.regwriteW = 0;
        bus.memtoregE = 0; bus.memtoregM = 0; bus.branchD = 0; bus.divstartE = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        now("reset_idle", ev(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset", ev(0, 0, 0, 0, 0, 0, 0, 0));

        // EX forwarding priority and $0
        bus.regwriteM = 1; bus.writeregM = 5; bus.regwriteW = 1; bus.writeregW = 5; bus.rsE = 5;
        step("fwd_mem_prio", ev(2'b10, 0, 0, 0, 0, 0, 0, 0));
        bus.regwriteM = 0;
        step("fwd_wb", ev(2'b01, 0, 0, 0, 0, 0, 0, 0));
        clear_inputs();
        bus.regwriteM = 1; bus.writeregM = 0; bus.rsE = 0;
        step("fwd_r0", ev(0, 0, 0, 0, 0, 0, 0, 0));
        clear_inputs();
        bus.rtE = 7; bus.regwriteW = 1; bus.writeregW = 7;
        step("fwd_b_wb", ev(0, 2'b01, 0, 0, 0, 0, 0, 0));

        // Randomised forwarding against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [1:0] fa, fb;
            logic       fad, fbd;
            clear_inputs();
            bus.rsE = 5'($urandom_range(0, 3));
            bus.rtE = 5'($urandom_range(0, 3));
            bus.rsD = 5'($urandom_range(4, 6));
            bus.rtD = 5'($urandom_range(4, 6));
            bus.writeregM = 5'($urandom_range(0, 5));
            bus.writeregW = 5'($urandom_range(0, 3));
            bus.regwriteM = 1'($urandom_range(0, 1));
            bus.regwriteW = 1'($urandom_range(0, 1));
            fa  = model_ex(bus.rsE, bus.regwriteM, bus.writeregM, bus.regwriteW, bus.writeregW);
            fb  = model_ex(bus.rtE, bus.regwriteM, bus.writeregM, bus.regwriteW, bus.writeregW);
            fad = bus.regwriteM && (bus.writeregM == bus.rsD);
            fbd = bus.regwriteM && (bus.writeregM == bus.rtD);
            step($sformatf("rnd_%0d", i), ev(fa, fb, fad, fbd, 0, 0, 0, 0));
        end

        // Load-use: one stall cycle with a bubble
        clear_inputs();
        bus.memtoregE = 1; bus.rtE = 8; bus.rsD = 8;
        step("loaduse", ev(0, 0, 0, 0, 1, 0, 1, 0));
        clear_inputs();
        step("loaduse_after", ev(0, 0, 0, 0, 0, 0, 0, 0));

        // Branch hazards and ID forwarding
        bus.branchD = 1; bus.rsD = 3; bus.memtoregM = 1; bus.writeregM = 3;
        step("br_load_mem", ev(0, 0, 0, 0, 1, 0, 1, 0));
        bus.memtoregM = 0; bus.regwriteM = 1;
        step("br_fwd_ad", ev(0, 0, 1, 0, 0, 0, 0, 0));
        bus.regwriteM = 0; bus.regwriteE = 1; bus.writeregE = 4; bus.rtD = 4;
        step("br_alu_ex", ev(0, 0, 0, 0, 1, 0, 1, 0));
        bus.branchD = 0;
        step("nobr_alu_ex", ev(0, 0, 0, 0, 0, 0, 0, 0));

        // Divide: exactly 4 stall cycles, lwstall inside must not flush
        clear_inputs();
        bus.divstartE = 1;
        step("div_c1", ev(0, 0, 0, 0, 1, 1, 0, 0));
        step("div_c2", ev(0, 0, 0, 0, 1, 1, 0, 1));
        bus.memtoregE = 1; bus.rtE = 8; bus.rsD = 8;
        step("div_c3_lw", ev(0, 0, 0, 0, 1, 1, 0, 1));
        bus.memtoregE = 0; bus.rtE = 0; bus.rsD = 0;
        step("div_c4", ev(0, 0, 0, 0, 1, 1, 0, 1));
        bus.divstartE = 0;
        step("div_done", ev(0, 0, 0, 0, 0, 0, 0, 1));
        step("div_idle", ev(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in the second BUSY cycle, then a fresh divide
        bus.divstartE = 1;
        step("rdiv_c1", ev(0, 0, 0, 0, 1, 1, 0, 0));
        step("rdiv_busy1", ev(0, 0, 0, 0, 1, 1, 0, 1));
        bus.divstartE = 0;
        now("rdiv_busy2", ev(0, 0, 0, 0, 1, 1, 0, 1));
        rst_n = 1'b0;
        now("rdiv_reset", ev(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.divstartE = 1;
        step("rdiv2_c1", ev(0, 0, 0, 0, 1, 1, 0, 0));
        step("rdiv2_c2", ev(0, 0, 0, 0, 1, 1, 0, 1));
        step("rdiv2_c3", ev(0, 0, 0, 0, 1, 1, 0, 1));
        step("rdiv2_c4", ev(0, 0, 0, 0, 1, 1, 0, 1));
        bus.divstartE = 0;
        step("rdiv2_done", ev(0, 0, 0, 0, 0, 0, 0, 1));
        step("rdiv2_idle", ev(0, 0, 0, 0, 0, 0, 0, 0));

        if (sb.size() != 0) check_val("sb_leftover", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_forward_ctrl.md
Name: ex_forward_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipelined MIPS core.
- Sits directly upstream of the EX-stage 3-input operand muxes and drives their 2-bit selects.
- Also drives the ID-stage branch-compare forwarding and the F/D/E stall and flush controls.
- Contains a sequential stall FSM for the multi-cycle divider in EX.

Parameters:
DIV_CYCLES, 32, number of stall cycles a divide holds the pipeline (legal range 2..63)
CNT_W, 6, width of the divide down-counter; must satisfy 2^CNT_W > DIV_CYCLES

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
rsD, rtD  input  5  source register numbers in ID
rsE, rtE  input  5  source register numbers in EX
writeregE, writeregM, writeregW  input  5  destination register numbers in EX/MEM/WB
regwriteE, regwriteM, regwriteW  input  1  destination write enables
memtoregE, memtoregM  input  1  instruction in that stage is a load
branchD  input  1  ID holds a branch
divstartE  input  1  EX holds a divide
forwardAE, forwardBE  output  2  EX mux select: 00 register file, 01 WB result, 10 MEM ALU result
forwardAD, forwardBD  output  1  ID compare operand taken from MEM ALU result
stallF, stallD, stallE  output  1  hold the PC, IF/ID and ID/EX registers
flushE  output  1  clear the ID/EX register (insert bubble)
div_busy  output  1  divide FSM not IDLE

Behaviour:
- Register $0 never matches any comparison below.
- EX forwarding (combinational, same cycle). Shown for A with rsE; B is identical with rtE:
  - forwardAE=10 if regwriteM && writeregM==rsE.
  - Else forwardAE=01 if regwriteW && writeregW==rsE.
  - Else 00.
  - MEM has priority when MEM and WB both match. Code 11 is never produced.
- ID forwarding: forwardAD = regwriteM && writeregM==rsD; forwardBD uses rtD.
- lwstall = memtoregE && (rtE==rsD || rtE==rtD).
- brstall = branchD && ((regwriteE && writeregE in {rsD,rtD}) || (memtoregM && writeregM in {rsD,rtD})).
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE->BUSY when divstartE=1; counter loads DIV_CYCLES-1.
  - BUSY: counter decrements each cycle; at counter==0 go to DONE.
  - DONE->IDLE unconditionally. divstartE is ignored in DONE, so the same divide never restarts.
  - divstall = (state==IDLE && divstartE) || state==BUSY. This gives exactly DIV_CYCLES stall cycles per divide.
  - div_busy = (state!=IDLE).
- Stall and flush outputs:
  - stallF = stallD = lwstall | brstall | divstall.
  - stallE = divstall.
  - flushE = (lwstall | brstall) & ~divstall. EX is held, never flushed, while a divide is stalling.
- All outputs are combinational from the inputs and the FSM state; no output latency beyond the FSM.
- Reset (asynchronous, any cycle, including mid-divide):
  - state=IDLE, counter=0.
  - divstall deasserts immediately; with idle inputs every output is 0.
  - After reset release, divstartE still high starts a fresh divide.

Optional Feature:
FWD_STATS_EN:
- Defined: adds outputs fwd_cnt[31:0] and stall_cnt[31:0], reset to 0.
  - fwd_cnt increments by 1 each cycle where any of forwardAE, forwardBE, forwardAD, forwardBD is nonzero.
  - stall_cnt increments each cycle stallF=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- MEM and WB priority: regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 -> forwardAE=10. Then regwriteM=0 -> forwardAE=01.
- Register $0: rsE=0, writeregM=0, regwriteM=1 -> forwardAE=00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1, stallE=0 for 1 cycle.
- Divide, DIV_CYCLES=4: divstartE held high -> stallE=1 for exactly 4 cycles, then 1 cycle of DONE with stalls low, then IDLE. Concurrent lwstall during the stall -> flushE=0.
- Reset mid-divide: rst_n low in the 2nd BUSY cycle -> stalls drop asynchronously, div_busy=0. Release with divstartE=1 -> a new 4-cycle stall.
- Branch: branchD=1, rsD=3, memtoregM=1, writeregM=3 -> stallD=1, flushE=1. With regwriteM=1 and no load -> forwardAD=1, no stall.
